// File: rtl/serial_memory_interface_if.sv
// rtl/serial_memory_interface_if.sv - decoder/memory pin bundle for serial_memory_interface
interface serial_memory_interface_if #(
  parameter int IO_BITS        = 2,
  parameter int PAYLOAD_CYCLES = 8
);
  localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;

  logic               tx_command_valid;
  logic [1:0]         tx_command;
  logic [IO_BITS-1:0] tx_data;
  logic               tx_command_started;
  logic               tx_active;
  logic               tx_data_next;
  logic               tx_done;
  logic [CW-1:0]      tx_counter;
  logic [IO_BITS-1:0] tx_pins;
  logic [IO_BITS-1:0] rx_pins;
  logic               rx_started;
  logic [IO_BITS-1:0] rx_sbs;
  logic               rx_sbs_valid;
  logic               rx_active;
  logic               rx_data_valid;
  logic               rx_done;
  logic [CW-1:0]      rx_counter;

  modport slave (
    input  tx_command_valid, tx_command, tx_data, rx_pins,
    output tx_command_started, tx_active, tx_data_next, tx_done, tx_counter, tx_pins,
    output rx_started, rx_sbs, rx_sbs_valid, rx_active, rx_data_valid, rx_done, rx_counter
  );

  modport master (
    output tx_command_valid, tx_command, tx_data, rx_pins,
    input  tx_command_started, tx_active, tx_data_next, tx_done, tx_counter, tx_pins,
    input  rx_started, rx_sbs, rx_sbs_valid, rx_active, rx_data_valid, rx_done, rx_counter
  );
endinterface

// File: rtl/serial_memory_interface.sv
// rtl/serial_memory_interface.sv - TX header/payload sequencer and RX start-bit/payload timer
module serial_memory_interface #(
  parameter int IO_BITS        = 2,
  parameter int PAYLOAD_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_memory_interface_if.slave bus
);
  localparam int CW = $clog2(PAYLOAD_CYCLES) + 1;
  localparam logic [CW-1:0]      RX_LAST       = CW'(PAYLOAD_CYCLES - 1);
  localparam logic [CW-1:0]      LAST_READ_16  = CW'(PAYLOAD_CYCLES - 1);
  localparam logic [CW-1:0]      LAST_WRITE_8  = CW'(PAYLOAD_CYCLES + PAYLOAD_CYCLES / 2 - 1);
  localparam logic [CW-1:0]      LAST_WRITE_16 = CW'(2 * PAYLOAD_CYCLES - 1);
  localparam logic [IO_BITS-1:0] RX_SB_READ_16 = IO_BITS'(1);

  typedef enum logic [1:0] {TX_IDLE, TX_HEADER, TX_PAYLOAD} tx_state_t;
  typedef enum logic       {RX_IDLE, RX_PAYLOAD} rx_state_t;

  tx_state_t     tx_state_q, tx_state_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [1:0]    tx_cmd_q;
  logic [CW-1:0] tx_cnt_q;
  logic [CW-1:0] rx_cnt_q;
  logic [CW-1:0] tx_last;
  logic          tx_accept;
  logic          rx_start;

  // Address is always one full payload; the command decides how much data follows it.
  always_comb begin
    tx_last = LAST_WRITE_16;
    case (tx_cmd_q)
      2'b01:   tx_last = LAST_READ_16;
      2'b10:   tx_last = LAST_WRITE_8;
      default: tx_last = LAST_WRITE_16;
    endcase
  end

  always_comb begin
    tx_state_d             = tx_state_q;
    tx_accept              = 1'b0;
    bus.tx_pins            = '0;
    bus.tx_command_started = 1'b0;
    bus.tx_active          = 1'b0;
    bus.tx_data_next       = 1'b0;
    bus.tx_done            = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_command_valid && bus.tx_command != 2'b00) begin
          tx_accept  = 1'b1;
          tx_state_d = TX_HEADER;
        end
      end
      TX_HEADER: begin
        bus.tx_pins            = IO_BITS'(tx_cmd_q);
        bus.tx_command_started = 1'b1;
        bus.tx_active          = 1'b1;
        tx_state_d             = TX_PAYLOAD;
      end
      TX_PAYLOAD: begin
        bus.tx_pins      = bus.tx_data;
        bus.tx_data_next = 1'b1;
        bus.tx_active    = 1'b1;
        if (tx_cnt_q == tx_last) begin
          bus.tx_done = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cmd_q   <= 2'b00;
      tx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      if (tx_accept) tx_cmd_q <= bus.tx_command;
      if (tx_state_q == TX_PAYLOAD && !bus.tx_done) tx_cnt_q <= tx_cnt_q + CW'(1);
      else                                          tx_cnt_q <= '0;
    end
  end

  assign bus.tx_counter = tx_cnt_q;

  // Start detection is gated by rst_n so every output reads zero while reset is held.
  assign rx_start = (rx_state_q == RX_IDLE) && rst_n && (bus.rx_pins != '0);

  always_comb begin
    rx_state_d        = rx_state_q;
    bus.rx_started    = rx_start;
    bus.rx_sbs_valid  = rx_start;
    bus.rx_active     = rx_start;
    bus.rx_data_valid = 1'b0;
    bus.rx_done       = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_start && bus.rx_pins == RX_SB_READ_16) rx_state_d = RX_PAYLOAD;
      end
      RX_PAYLOAD: begin
        bus.rx_active     = 1'b1;
        bus.rx_data_valid = 1'b1;
        if (rx_cnt_q == RX_LAST) begin
          bus.rx_done = 1'b1;
          rx_state_d  = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      bus.rx_sbs <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      if (rx_start) bus.rx_sbs <= bus.rx_pins;
      if (rx_state_q == RX_PAYLOAD && !bus.rx_done) rx_cnt_q <= rx_cnt_q + CW'(1);
      else                                          rx_cnt_q <= '0;
    end
  end

  assign bus.rx_counter = rx_cnt_q;
endmodule

// File: tb/tb_serial_memory_interface.sv
// tb/tb_serial_memory_interface.sv - self-checking bench for serial_memory_interface
module tb_serial_memory_interface;
  localparam int IO_BITS = 2;
  localparam int P       = 8;
  localparam int CW      = $clog2(P) + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [IO_BITS-1:0] exp_sbs;

  always #5 clk = ~clk;

  serial_memory_interface_if #(.IO_BITS(IO_BITS), .PAYLOAD_CYCLES(P)) bus ();

  serial_memory_interface #(.IO_BITS(IO_BITS), .PAYLOAD_CYCLES(P)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_outputs(
    input logic [IO_BITS-1:0] e_pins, input logic e_started, input logic e_active,
    input logic e_next, input logic e_done, input logic [CW-1:0] e_cnt,
    input logic e_rst, input logic [IO_BITS-1:0] e_sbs, input logic e_ract,
    input logic e_dv, input logic e_rdone, input logic [CW-1:0] e_rcnt);
    chk("tx_pins",            bus.tx_pins,            e_pins);
    chk("tx_command_started", bus.tx_command_started, e_started);
    chk("tx_active",          bus.tx_active,          e_active);
    chk("tx_data_next",       bus.tx_data_next,       e_next);
    chk("tx_done",            bus.tx_done,            e_done);
    chk("tx_counter",         bus.tx_counter,         e_cnt);
    chk("rx_started",         bus.rx_started,         e_rst);
    chk("rx_sbs_valid",       bus.rx_sbs_valid,       e_rst);
    chk("rx_sbs",             bus.rx_sbs,             e_sbs);
    chk("rx_active",          bus.rx_active,          e_ract);
    chk("rx_data_valid",      bus.rx_data_valid,      e_dv);
    chk("rx_done",            bus.rx_done,            e_rdone);
    chk("rx_counter",         bus.rx_counter,         e_rcnt);
  endtask

  function automatic int frame_len(input logic [1:0] cmd);
    case (cmd)
      2'b01:   return P;
      2'b10:   return P + P / 2;
      2'b11:   return 2 * P;
      default: return 0;
    endcase
  endfunction

  // One TX command and/or one RX start symbol issued at cycle 0; expectations come from cycle offsets.
  task automatic frame(input logic [1:0] cmd, input logic do_tx,
                       input logic [IO_BITS-1:0] sbs, input logic do_rx, input int abort_at);
    int  len, n;
    bit  tx_frame, rx_read, hdr, pay, st, rp;
    logic [IO_BITS-1:0] e_pins;
    tx_frame = do_tx && cmd != 2'b00;
    rx_read  = do_rx && sbs == IO_BITS'(1);
    len      = frame_len(cmd);
    n        = 2;
    if (tx_frame && len + 3 > n) n = len + 3;
    if (rx_read && P + 2 > n)    n = P + 2;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      bus.tx_command_valid = do_tx && c <= 1;
      bus.tx_command       = cmd;
      bus.tx_data          = IO_BITS'($urandom);
      if (do_rx && c == 0)                   bus.rx_pins = sbs;
      else if (rx_read && c >= 1 && c <= P)  bus.rx_pins = IO_BITS'($urandom);
      else                                   bus.rx_pins = '0;
      if (do_rx && sbs != '0 && c == 1) exp_sbs = sbs;
      #1;
      hdr    = tx_frame && c == 1;
      pay    = tx_frame && c >= 2 && c <= len + 1;
      st     = do_rx && sbs != '0 && c == 0;
      rp     = rx_read && c >= 1 && c <= P;
      e_pins = hdr ? IO_BITS'(cmd) : (pay ? bus.tx_data : '0);
      check_outputs(e_pins, hdr, hdr || pay, pay, pay && (c - 2 == len - 1),
                    pay ? CW'(c - 2) : '0,
                    st, exp_sbs, st || rp, rp, rp && (c - 1 == P - 1),
                    rp ? CW'(c - 1) : '0);
      if (c == abort_at) begin
        rst_n   = 1'b0;
        exp_sbs = '0;
        #1;
        check_outputs('0, 0, 0, 0, 0, '0, 0, '0, 0, 0, 0, '0);
        @(negedge clk);
        bus.tx_command_valid = 1'b0;
        bus.rx_pins          = '0;
        #1;
        check_outputs('0, 0, 0, 0, 0, '0, 0, '0, 0, 0, 0, '0);
        rst_n = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst_n                = 1'b0;
    exp_sbs              = '0;
    bus.tx_command_valid = 1'b0;
    bus.tx_command       = 2'b00;
    bus.tx_data          = '0;
    bus.rx_pins          = '0;
    repeat (2) @(negedge clk);
    #1;
    check_outputs('0, 0, 0, 0, 0, '0, 0, '0, 0, 0, 0, '0);
    rst_n = 1'b1;

    frame(2'b01, 1, '0, 0, -1);
    frame(2'b11, 1, '0, 0, -1);
    frame(2'b10, 1, '0, 0, -1);
    frame(2'b00, 1, '0, 0, -1);
    frame(2'b00, 0, 2'b01, 1, -1);
    frame(2'b00, 0, 2'b10, 1, -1);
    frame(2'b00, 0, 2'b11, 1, -1);
    frame(2'b11, 1, 2'b01, 1, -1);
    frame(2'b01, 1, 2'b01, 1, 5);
    frame(2'b01, 1, '0, 0, -1);
    frame(2'b10, 1, 2'b01, 1, -1);

    for (int k = 0; k < 12; k++) begin
      frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            IO_BITS'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
